// File: rtl/sram_counter_ctrl_if.sv
// Host, tick and SRAM signals of the counter-bank controller.
// The slave modport is the controller; master is the surrounding system.
interface sram_counter_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              TICK;
    logic              HOST_REQ;
    logic [ADDR_W-1:0] HOST_ADDR;
    logic              HOST_ACK;
    logic [DATA_W-1:0] HOST_DATA;
    logic              SRAM_CE;
    logic              SRAM_WE;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic [DATA_W-1:0] SRAM_WDATA;
    logic [DATA_W-1:0] SRAM_RDATA;
    logic [ADDR_W-1:0] PTR;
    logic              BUSY;
    logic              OVERRUN;

    modport slave (
        input  TICK, HOST_REQ, HOST_ADDR, SRAM_RDATA,
        output HOST_ACK, HOST_DATA, SRAM_CE, SRAM_WE, SRAM_ADDR, SRAM_WDATA,
               PTR, BUSY, OVERRUN
    );

    modport master (
        output TICK, HOST_REQ, HOST_ADDR, SRAM_RDATA,
        input  HOST_ACK, HOST_DATA, SRAM_CE, SRAM_WE, SRAM_ADDR, SRAM_WDATA,
               PTR, BUSY, OVERRUN
    );
endinterface

// File: rtl/sram_counter_ctrl.sv
// Tick-driven read-modify-write counter bank in SRAM with a host read port.
// Optional macro SRAM_CNT_SAT_EN: counters saturate at all-ones instead of wrapping.
module sram_counter_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input logic                CLK,
    input logic                RST,
    sram_counter_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RMW_RD,
        RMW_WAIT,
        RMW_WR,
        HOST_RD,
        HOST_WAIT,
        HOST_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              tick_pend;
    logic              req_q;
    logic              overrun;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] host_addr_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] host_data;
    logic [DATA_W-1:0] inc_val;
    logic              pend_clr;

    assign pend_clr = (state == IDLE) && tick_pend;

`ifdef SRAM_CNT_SAT_EN
    assign inc_val = (&rd_q) ? rd_q : rd_q + DATA_W'(1);
`else
    assign inc_val = rd_q + DATA_W'(1);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            tick_pend   <= 1'b0;
            req_q       <= 1'b0;
            overrun     <= 1'b0;
            ptr         <= '0;
            host_addr_q <= '0;
            rd_q        <= '0;
            host_data   <= '0;
        end else begin
            state <= state_nxt;
            // A request still high during the ACK cycle belongs to the read just
            // completed; only a request seen after it starts another read.
            req_q <= bus.HOST_REQ && (state != HOST_DONE);
            if (bus.TICK)
                tick_pend <= 1'b1;
            else if (pend_clr)
                tick_pend <= 1'b0;
            if (bus.TICK && tick_pend && !pend_clr)
                overrun <= 1'b1;
            if (state == IDLE && !tick_pend && req_q)
                host_addr_q <= bus.HOST_ADDR;
            if (state == RMW_WAIT)
                rd_q <= bus.SRAM_RDATA;
            if (state == HOST_WAIT)
                host_data <= bus.SRAM_RDATA;
            if (state == RMW_WR)
                ptr <= ptr + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (tick_pend)
                    state_nxt = RMW_RD;
                else if (req_q)
                    state_nxt = HOST_RD;
            end
            RMW_RD:    state_nxt = RMW_WAIT;
            RMW_WAIT:  state_nxt = RMW_WR;
            RMW_WR:    state_nxt = IDLE;
            HOST_RD:   state_nxt = HOST_WAIT;
            HOST_WAIT: state_nxt = HOST_DONE;
            HOST_DONE: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.SRAM_CE    = 1'b0;
        bus.SRAM_WE    = 1'b0;
        bus.SRAM_ADDR  = '0;
        bus.SRAM_WDATA = '0;
        case (state)
            RMW_RD: begin
                bus.SRAM_CE   = 1'b1;
                bus.SRAM_ADDR = ptr;
            end
            RMW_WR: begin
                bus.SRAM_CE    = 1'b1;
                bus.SRAM_WE    = 1'b1;
                bus.SRAM_ADDR  = ptr;
                bus.SRAM_WDATA = inc_val;
            end
            HOST_RD: begin
                bus.SRAM_CE   = 1'b1;
                bus.SRAM_ADDR = host_addr_q;
            end
            default: ;
        endcase
    end

    assign bus.HOST_ACK  = (state == HOST_DONE);
    assign bus.HOST_DATA = host_data;
    assign bus.PTR       = ptr;
    assign bus.BUSY      = (state != IDLE);
    assign bus.OVERRUN   = overrun;

endmodule

// File: tb/tb_sram_counter_ctrl.sv
// Randomized and directed bench for sram_counter_ctrl with an SRAM model and
// a counter-bank reference model.
module tb_sram_counter_ctrl;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    sram_counter_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    sram_counter_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.CLK(clk), .RST(rst), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: read data appears the cycle after a read access; accesses logged
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] pl_mem [DEPTH];
    int pl_gen = 0, pl_seen = 0;
    int w_addr[$], w_data[$], w_cyc[$], a_data[$];
    int ce_cnt = 0, busy_cnt = 0;

    always @(negedge clk) begin
        if (pl_gen != pl_seen) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pl_mem[i];
            pl_seen <= pl_gen;
        end
        if (bus.SRAM_CE) begin
            ce_cnt <= ce_cnt + 1;
            if (bus.SRAM_WE) begin
                mem[bus.SRAM_ADDR] <= bus.SRAM_WDATA;
                w_addr.push_back(int'(bus.SRAM_ADDR));
                w_data.push_back(int'(bus.SRAM_WDATA));
                w_cyc.push_back(cyc);
            end else begin
                bus.SRAM_RDATA <= mem[bus.SRAM_ADDR];
            end
        end
        if (bus.HOST_ACK) a_data.push_back(int'(bus.HOST_DATA));
        if (bus.BUSY) busy_cnt <= busy_cnt + 1;
    end

    // reference model of the counter bank
    int ref_mem [DEPTH];
    int ref_ptr;

    function automatic int bump(input int v);
`ifdef SRAM_CNT_SAT_EN
        return (v == (1 << DW) - 1) ? v : v + 1;
`else
        return (v + 1) % (1 << DW);
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.TICK = 1'b0;
        bus.HOST_REQ = 1'b0;
        step(2);
        rst = 1'b0;
        ref_ptr = 0;
    endtask

    task automatic load_zero();
        for (int i = 0; i < DEPTH; i++) begin
            pl_mem[i] = '0;
            ref_mem[i] = 0;
        end
    endtask

    task automatic commit_load();
        pl_gen++;
        step(1);
    endtask

    task automatic pulse_tick();
        bus.TICK = 1'b1;
        step(1);
        bus.TICK = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.TICK = 1'b1;
        bus.HOST_REQ = 1'b1;
        bus.HOST_ADDR = '0;
        step(3);
        n_chk++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", bus.BUSY); end
        n_chk++; if (bus.PTR !== '0) begin n_err++; $display("FAIL reset_ptr got=%0d exp=0", bus.PTR); end
        n_chk++; if (bus.OVERRUN !== 1'b0) begin n_err++; $display("FAIL reset_overrun got=%0b exp=0", bus.OVERRUN); end
        n_chk++; if (bus.HOST_ACK !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%0b exp=0", bus.HOST_ACK); end
        n_chk++; if (bus.HOST_DATA !== '0) begin n_err++; $display("FAIL reset_hdata got=%0h exp=0", bus.HOST_DATA); end
        n_chk++; if (bus.SRAM_CE !== 1'b0 || bus.SRAM_WE !== 1'b0) begin n_err++; $display("FAIL reset_ce_we got=%0b%0b exp=00", bus.SRAM_CE, bus.SRAM_WE); end
        n_chk++; if (bus.SRAM_ADDR !== '0 || bus.SRAM_WDATA !== '0) begin n_err++; $display("FAIL reset_addr_wdata got=%0h/%0h exp=0/0", bus.SRAM_ADDR, bus.SRAM_WDATA); end
        bus.TICK = 1'b0;
        bus.HOST_REQ = 1'b0;
        step(1);
        rst = 1'b0;
        step(3);
        n_chk++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL reset_release_busy got=%0b exp=0", bus.BUSY); end
    endtask

    task automatic test_single_tick();
        int wi, b0, t0;
        load_zero();
        commit_load();
        do_reset();
        step(1);
        wi = w_addr.size();
        b0 = busy_cnt;
        t0 = cyc;
        pulse_tick();
        step(8);
        n_chk++;
        if (w_addr.size() != wi + 1) begin
            n_err++; $display("FAIL single_wcount got=%0d exp=1", w_addr.size() - wi);
        end else begin
            n_chk++; if (w_addr[wi] != 0) begin n_err++; $display("FAIL single_waddr got=%0d exp=0", w_addr[wi]); end
            n_chk++; if (w_data[wi] != 1) begin n_err++; $display("FAIL single_wdata got=%0h exp=1", w_data[wi]); end
            n_chk++; if (w_cyc[wi] != t0 + 4) begin n_err++; $display("FAIL single_wlat got=%0d exp=%0d", w_cyc[wi] - t0, 4); end
        end
        n_chk++; if (bus.PTR !== 4'd1) begin n_err++; $display("FAIL single_ptr got=%0d exp=1", bus.PTR); end
        n_chk++; if (busy_cnt - b0 != 3) begin n_err++; $display("FAIL single_busy got=%0d exp=3", busy_cnt - b0); end
    endtask

    task automatic test_sweep();
        int wi, t0, exp_d;
        load_zero();
        commit_load();
        do_reset();
        for (int k = 0; k < DEPTH + 1; k++) begin
            wi = w_addr.size();
            t0 = cyc;
            pulse_tick();
            step(1000);
            exp_d = bump(ref_mem[ref_ptr]);
            n_chk++;
            if (w_addr.size() != wi + 1) begin
                n_err++; $display("FAIL sweep_wcount tick=%0d got=%0d exp=1", k, w_addr.size() - wi);
            end else begin
                n_chk++; if (w_addr[wi] != ref_ptr) begin n_err++; $display("FAIL sweep_waddr tick=%0d got=%0d exp=%0d", k, w_addr[wi], ref_ptr); end
                n_chk++; if (w_data[wi] != exp_d) begin n_err++; $display("FAIL sweep_wdata tick=%0d got=%0h exp=%0h", k, w_data[wi], exp_d); end
                n_chk++; if (w_cyc[wi] != t0 + 4) begin n_err++; $display("FAIL sweep_wlat tick=%0d got=%0d exp=4", k, w_cyc[wi] - t0); end
            end
            ref_mem[ref_ptr] = exp_d;
            ref_ptr = (ref_ptr + 1) % DEPTH;
            if (k == DEPTH - 1) begin
                n_chk++; if (bus.PTR !== '0) begin n_err++; $display("FAIL sweep_ptr_wrap got=%0d exp=0", bus.PTR); end
            end
        end
        n_chk++; if (bus.PTR !== AW'(ref_ptr)) begin n_err++; $display("FAIL sweep_ptr_end got=%0d exp=%0d", bus.PTR, ref_ptr); end
        n_chk++; if (bus.OVERRUN !== 1'b0) begin n_err++; $display("FAIL sweep_overrun got=%0b exp=0", bus.OVERRUN); end
    endtask

    task automatic test_tick_host();
        int wi, ai, t0, n;
        load_zero();
        pl_mem[5] = 16'h1234;
        commit_load();
        do_reset();
        wi = w_addr.size();
        ai = a_data.size();
        t0 = cyc;
        bus.TICK = 1'b1;
        bus.HOST_REQ = 1'b1;
        bus.HOST_ADDR = 4'd5;
        step(1);
        bus.TICK = 1'b0;
        n = 0;
        while (!bus.HOST_ACK && n < 30) begin step(1); n++; end
        bus.HOST_REQ = 1'b0;
        n_chk++; if (bus.HOST_ACK !== 1'b1) begin n_err++; $display("FAIL th_ack_timeout got=%0b exp=1", bus.HOST_ACK); end
        n_chk++; if (cyc - t0 != 8) begin n_err++; $display("FAIL th_ack_lat got=%0d exp=8", cyc - t0); end
        n_chk++; if (bus.HOST_DATA !== 16'h1234) begin n_err++; $display("FAIL th_hdata got=%0h exp=1234", bus.HOST_DATA); end
        n_chk++;
        if (w_addr.size() != wi + 1) begin
            n_err++; $display("FAIL th_wcount got=%0d exp=1", w_addr.size() - wi);
        end else begin
            n_chk++; if (w_cyc[wi] != t0 + 4 || w_addr[wi] != 0) begin n_err++; $display("FAIL th_rmw_first got=cyc%0d/addr%0d exp=cyc4/addr0", w_cyc[wi] - t0, w_addr[wi]); end
        end
        step(4);
        n_chk++; if (bus.HOST_DATA !== 16'h1234) begin n_err++; $display("FAIL th_hdata_hold got=%0h exp=1234", bus.HOST_DATA); end
        n_chk++; if (a_data.size() != ai + 1) begin n_err++; $display("FAIL th_ack_count got=%0d exp=1", a_data.size() - ai); end
    endtask

    task automatic test_overrun();
        int wi;
        load_zero();
        commit_load();
        do_reset();
        wi = w_addr.size();
        bus.TICK = 1'b1;
        step(2);
        bus.TICK = 1'b0;
        step(12);
        n_chk++; if (w_addr.size() - wi != 2) begin n_err++; $display("FAIL ov_two_writes got=%0d exp=2", w_addr.size() - wi); end
        n_chk++; if (bus.OVERRUN !== 1'b0) begin n_err++; $display("FAIL ov_two_flag got=%0b exp=0", bus.OVERRUN); end
        n_chk++; if (bus.PTR !== 4'd2) begin n_err++; $display("FAIL ov_two_ptr got=%0d exp=2", bus.PTR); end
        bus.TICK = 1'b1;
        step(3);
        bus.TICK = 1'b0;
        step(12);
        n_chk++; if (bus.OVERRUN !== 1'b1) begin n_err++; $display("FAIL ov_three_flag got=%0b exp=1", bus.OVERRUN); end
        n_chk++; if (w_addr.size() - wi != 4) begin n_err++; $display("FAIL ov_three_writes got=%0d exp=4", w_addr.size() - wi); end
        step(20);
        n_chk++; if (bus.OVERRUN !== 1'b1) begin n_err++; $display("FAIL ov_sticky got=%0b exp=1", bus.OVERRUN); end
        do_reset();
        n_chk++; if (bus.OVERRUN !== 1'b0) begin n_err++; $display("FAIL ov_reset_clear got=%0b exp=0", bus.OVERRUN); end
    endtask

    task automatic test_saturate();
        int wi;
        int exp0;
        load_zero();
        pl_mem[0] = 16'hFFFF;
        pl_mem[1] = 16'hFFFE;
        commit_load();
        do_reset();
`ifdef SRAM_CNT_SAT_EN
        exp0 = 16'hFFFF;
`else
        exp0 = 0;
`endif
        wi = w_addr.size();
        pulse_tick();
        step(8);
        pulse_tick();
        step(8);
        n_chk++;
        if (w_addr.size() != wi + 2) begin
            n_err++; $display("FAIL sat_wcount got=%0d exp=2", w_addr.size() - wi);
        end else begin
            n_chk++; if (w_data[wi] != exp0) begin n_err++; $display("FAIL sat_allones got=%0h exp=%0h", w_data[wi], exp0); end
            n_chk++; if (w_data[wi+1] != 16'hFFFF) begin n_err++; $display("FAIL sat_fffe got=%0h exp=ffff", w_data[wi+1]); end
        end
    endtask

    task automatic test_reset_mid();
        int wi, c0;
        load_zero();
        commit_load();
        do_reset();
        wi = w_addr.size();
        c0 = ce_cnt;
        pulse_tick();
        step(2);
        rst = 1'b1;
        step(1);
        n_chk++; if (bus.BUSY !== 1'b0 || bus.PTR !== '0) begin n_err++; $display("FAIL mid_state got=busy%0b/ptr%0d exp=busy0/ptr0", bus.BUSY, bus.PTR); end
        n_chk++; if (bus.SRAM_CE !== 1'b0 || bus.SRAM_WE !== 1'b0 || bus.SRAM_ADDR !== '0 || bus.SRAM_WDATA !== '0) begin n_err++; $display("FAIL mid_sram got=%0b%0b/%0h/%0h exp=00/0/0", bus.SRAM_CE, bus.SRAM_WE, bus.SRAM_ADDR, bus.SRAM_WDATA); end
        n_chk++; if (bus.HOST_ACK !== 1'b0 || bus.OVERRUN !== 1'b0) begin n_err++; $display("FAIL mid_flags got=%0b%0b exp=00", bus.HOST_ACK, bus.OVERRUN); end
        rst = 1'b0;
        step(6);
        n_chk++; if (w_addr.size() != wi) begin n_err++; $display("FAIL mid_no_write got=%0d exp=0", w_addr.size() - wi); end
        n_chk++; if (ce_cnt - c0 != 1) begin n_err++; $display("FAIL mid_access_count got=%0d exp=1", ce_cnt - c0); end
    endtask

    task automatic test_random();
        int op, addr, wi, ai, c0, t0, n, exp_d, lat;
        for (int i = 0; i < DEPTH; i++) begin
            pl_mem[i] = DW'($urandom_range(0, 16'hFFFE));
            ref_mem[i] = int'(pl_mem[i]);
        end
        commit_load();
        do_reset();
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 2);
            addr = $urandom_range(0, DEPTH - 1);
            step($urandom_range(0, 4));
            wi = w_addr.size();
            ai = a_data.size();
            c0 = ce_cnt;
            t0 = cyc;
            bus.TICK = (op != 1);
            bus.HOST_REQ = (op != 0);
            bus.HOST_ADDR = AW'(addr);
            step(1);
            bus.TICK = 1'b0;
            if (op == 1) begin
                lat = 4;
            end else begin
                lat = 8;
                step(5);
                exp_d = bump(ref_mem[ref_ptr]);
                n_chk++;
                if (w_addr.size() != wi + 1) begin
                    n_err++; $display("FAIL rnd_wcount it=%0d got=%0d exp=1", it, w_addr.size() - wi);
                end else begin
                    n_chk++; if (w_addr[wi] != ref_ptr || w_data[wi] != exp_d) begin n_err++; $display("FAIL rnd_write it=%0d got=%0d:%0h exp=%0d:%0h", it, w_addr[wi], w_data[wi], ref_ptr, exp_d); end
                end
                ref_mem[ref_ptr] = exp_d;
                ref_ptr = (ref_ptr + 1) % DEPTH;
            end
            if (op != 0) begin
                n = 0;
                while (!bus.HOST_ACK && n < 30) begin step(1); n++; end
                bus.HOST_REQ = 1'b0;
                n_chk++; if (!bus.HOST_ACK || cyc - t0 != lat) begin n_err++; $display("FAIL rnd_ack it=%0d got=lat%0d/ack%0b exp=lat%0d", it, cyc - t0, bus.HOST_ACK, lat); end
                n_chk++; if (bus.HOST_DATA !== DW'(ref_mem[addr])) begin n_err++; $display("FAIL rnd_hdata it=%0d addr=%0d got=%0h exp=%0h", it, addr, bus.HOST_DATA, ref_mem[addr]); end
            end
            step(2);
            n_chk++; if (ce_cnt - c0 != (op == 0 ? 2 : (op == 1 ? 1 : 3))) begin n_err++; $display("FAIL rnd_accesses it=%0d op=%0d got=%0d", it, op, ce_cnt - c0); end
        end
        n_chk++; if (bus.PTR !== AW'(ref_ptr)) begin n_err++; $display("FAIL rnd_ptr got=%0d exp=%0d", bus.PTR, ref_ptr); end
        n_chk++; if (bus.OVERRUN !== 1'b0) begin n_err++; $display("FAIL rnd_overrun got=%0b exp=0", bus.OVERRUN); end
    endtask

    initial begin
        bus.TICK = 1'b0;
        bus.HOST_REQ = 1'b0;
        bus.HOST_ADDR = '0;
        test_reset();
        test_single_tick();
        test_sweep();
        test_tick_host();
        test_overrun();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sram_counter_ctrl.md
SRAM_COUNTER_CTRL -- requirements
Module: sram_counter_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, SRAM address width; counter bank depth = 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM word / counter width.
REQ-003 SHALL have port CLK  input  1  system clock; all logic on posedge CLK.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port TICK  input  1  one-cycle update strobe from the 1 kHz pulse generator.
REQ-006 SHALL have port HOST_REQ  input  1  host read request, level, held until HOST_ACK.
REQ-007 SHALL have port HOST_ADDR  input  ADDR_W  host read address, stable while HOST_REQ=1.
REQ-008 SHALL have port HOST_ACK  output  1  one-cycle host read completion strobe.
REQ-009 SHALL have port HOST_DATA  output  DATA_W  host read data, valid when HOST_ACK=1, held until next ACK.
REQ-010 SHALL have port SRAM_CE  output  1  SRAM access enable.
REQ-011 SHALL have port SRAM_WE  output  1  SRAM write enable (1 = write, qualified by SRAM_CE).
REQ-012 SHALL have port SRAM_ADDR  output  ADDR_W  SRAM address.
REQ-013 SHALL have port SRAM_WDATA  output  DATA_W  SRAM write data.
REQ-014 SHALL have port SRAM_RDATA  input  DATA_W  SRAM read data, valid the cycle after a read access.
REQ-015 SHALL have port PTR  output  ADDR_W  address of the next counter to be updated.
REQ-016 SHALL have port BUSY  output  1  high whenever FSM is not IDLE.
REQ-017 SHALL have port OVERRUN  output  1  sticky flag: a TICK was dropped.

Function
REQ-018 SHALL implement FSM states IDLE, RMW_RD, RMW_WAIT, RMW_WR, HOST_RD, HOST_WAIT, HOST_DONE; all outputs registered or decoded from state only.
REQ-019 SHALL set internal tick_pend on TICK=1; clear tick_pend on the IDLE->RMW_RD transition; TICK in that same cycle re-sets it (set wins).
REQ-020 SHALL set OVERRUN when TICK=1 while tick_pend=1 and no clear occurs that cycle; the tick is dropped.
REQ-021 IDLE: tick_pend=1 -> RMW_RD (priority over host); else HOST_REQ=1 -> HOST_RD; else stay.
REQ-022 RMW_RD (1 cycle): SRAM_CE=1, SRAM_WE=0, SRAM_ADDR=PTR; -> RMW_WAIT.
REQ-023 RMW_WAIT (1 cycle): SRAM_CE=0; capture SRAM_RDATA; -> RMW_WR.
REQ-024 RMW_WR (1 cycle): SRAM_CE=1, SRAM_WE=1, SRAM_ADDR=PTR, SRAM_WDATA=captured+1 mod 2^DATA_W; PTR increments on exit, wrapping 2^ADDR_W-1 -> 0; -> IDLE.
REQ-025 HOST_RD (1 cycle): SRAM_CE=1, SRAM_WE=0, SRAM_ADDR=HOST_ADDR latched on IDLE exit; -> HOST_WAIT.
REQ-026 HOST_WAIT (1 cycle): capture SRAM_RDATA into HOST_DATA; -> HOST_DONE.
REQ-027 HOST_DONE (1 cycle): HOST_ACK=1; -> IDLE; HOST_REQ still high next cycle starts a new read.
REQ-028 SHALL never abort a sequence in progress; TICK/HOST_REQ during any non-IDLE state are only recorded/held.
REQ-029 Outside RMW_RD, RMW_WR, HOST_RD: SRAM_CE=0, SRAM_WE=0.
REQ-030 RMW latency: TICK in IDLE -> SRAM write exactly 3 cycles later; host latency: HOST_REQ in IDLE -> HOST_ACK 3 cycles later, or 7 if tick_pend was set.

Reset
REQ-031 SHALL, with RST=1 at a clock edge, force state IDLE, PTR=0, tick_pend=0, OVERRUN=0, HOST_ACK=0, HOST_DATA=0, SRAM_CE=0, SRAM_WE=0, SRAM_ADDR=0, SRAM_WDATA=0, BUSY=0.
REQ-032 RST mid-sequence SHALL abandon the sequence with no further SRAM write; RST has priority over TICK and HOST_REQ.
REQ-033 SHALL not clear SRAM contents on reset.

Configuration
REQ-034 With macro SRAM_CNT_SAT_EN defined, RMW_WR SHALL write captured+1 saturated at 2^DATA_W-1 (all-ones stays all-ones); without it, increment wraps to 0.

Verification
REQ-035 Reset, SRAM preloaded 0; TICK once -> cycle+3 write addr 0 data 1; PTR=1; BUSY high exactly 3 cycles.
REQ-036 16 TICKs spaced 1001 cycles (ADDR_W=4) -> addresses 0..15 each written 1, PTR wraps to 0; 17th TICK writes addr 0 data 2; OVERRUN=0.
REQ-037 TICK and HOST_REQ (addr 5, SRAM[5]=0x1234) same cycle -> RMW first, HOST_ACK at cycle+7, HOST_DATA=0x1234.
REQ-038 TICK at cycle 0 and cycle 1 (pending not yet cleared at edge 1 -> clear and set same cycle) -> two RMWs, OVERRUN=0; TICK at cycles 0,1,2 with FSM busy -> OVERRUN=1 sticky until RST.
REQ-039 SRAM[0]=0xFFFF, TICK -> write 0x0000 without SRAM_CNT_SAT_EN, 0xFFFF with it.
REQ-040 RST asserted in RMW_WAIT -> no write, PTR=0, all outputs at reset values next cycle.
